// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_LATENCY = MD_WIDTH + 2;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } md_state_t;

  function automatic logic [MD_WIDTH-1:0] abs_val(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // remainder gains one bit on the shift, so the trial subtract is WIDTH+1 wide
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd};
    ge     = (rem_sh >= {1'b0, opnd});
    acc_next = '0;
    if (is_div) begin
      if (ge) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else    acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO controller for MULT/MULTU/DIV/DIVU with MTHI/MTLO and stall generation.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_read,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             hold,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [2*WIDTH-1:0] acc_q, acc_n, step_out;
  logic [WIDTH-1:0]   opnd_q, opnd_n;
  logic               is_div_q, is_div_n;
  logic               neg_q, neg_n;
  logic               rem_neg_q, rem_neg_n;
  logic               bzero_q, bzero_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic               busy_n, done_n, div_zero_n;

  md_op_t             op_e;
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_out)
  );

  assign hold = busy & (start | hilo_read | mt_hi | mt_lo);

  always_comb begin
    op_e      = md_op_t'(op);
    signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
    a_neg     = signed_op & operand_a[WIDTH-1];
    b_neg     = signed_op & operand_b[WIDTH-1];
    abs_a     = a_neg ? (~operand_a + 1'b1) : operand_a;
    abs_b     = b_neg ? (~operand_b + 1'b1) : operand_b;
    prod      = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot      = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem       = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    state_n    = state_q;
    cnt_n      = cnt_q;
    acc_n      = acc_q;
    opnd_n     = opnd_q;
    is_div_n   = is_div_q;
    neg_n      = neg_q;
    rem_neg_n  = rem_neg_q;
    bzero_n    = bzero_q;
    hi_n       = hi;
    lo_n       = lo;
    busy_n     = busy;
    done_n     = 1'b0;
    div_zero_n = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_n   = MD_RUN;
          cnt_n     = '0;
          busy_n    = 1'b1;
          is_div_n  = op[1];
          neg_n     = a_neg ^ b_neg;
          rem_neg_n = a_neg;
          bzero_n   = (operand_b == '0);
          // multiply walks the multiplier in the low half; divide shifts the dividend out of it
          if (op[1]) begin
            acc_n  = {{WIDTH{1'b0}}, abs_a};
            opnd_n = abs_b;
          end else begin
            acc_n  = {{WIDTH{1'b0}}, abs_b};
            opnd_n = abs_a;
          end
        end else begin
          if (mt_hi) hi_n = mt_data;
          if (mt_lo) lo_n = mt_data;
        end
      end
      MD_RUN: begin
        acc_n = step_out;
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_n = MD_FIX;
      end
      MD_FIX: begin
        state_n = MD_IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        if (is_div_q) begin
          if (bzero_q) begin
            div_zero_n = 1'b1;
          end else begin
            lo_n = quot;
            hi_n = rem;
          end
        end else begin
          hi_n = prod[2*WIDTH-1:WIDTH];
          lo_n = prod[WIDTH-1:0];
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      acc_q     <= acc_n;
      opnd_q    <= opnd_n;
      is_div_q  <= is_div_n;
      neg_q     <= neg_n;
      rem_neg_q <= rem_neg_n;
      bzero_q   <= bzero_n;
      hi        <= hi_n;
      lo        <= lo_n;
      busy      <= busy_n;
      done      <= done_n;
      div_zero  <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

  logic        clk, rst, start, hilo_read, mt_hi, mt_lo;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b, mt_data;
  logic        busy, done, div_zero, hold;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hilo_read(hilo_read), .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hold(hold),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one edge; returns edges until done, busy cycles seen, div_zero at done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc, output logic dz);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    lat = -1; bcyc = 0; dz = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      start = 1'b0;
      if (done) begin
        lat = i;
        dz  = div_zero;
        break;
      end
      if (busy) bcyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_zero); end
    tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
  endtask

  task automatic test_multu();
    int lat, bc; logic dz;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz);
    tests++; if (lat !== 34) begin fails++; $display("FAIL multu_latency got %0d want 34", lat); end
    tests++; if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      fails++; $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
  endtask

  task automatic test_mult();
    int lat, bc; logic dz;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bc, dz);
    tests++; if (lat !== 34) begin fails++; $display("FAIL mult_latency got %0d want 34", lat); end
    tests++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      fails++; $display("FAIL mult_result got %h_%h want ffffffff_ffffffeb", hi, lo); end
  endtask

  task automatic test_div();
    int lat, bc; logic dz;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc, dz);
    tests++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL div_result got lo=%h hi=%h want lo=fffffffd hi=ffffffff", lo, hi); end
    tests++; if (dz !== 1'b0) begin fails++; $display("FAIL div_nozero_flag got %b want 0", dz); end
    run_op(2'b11, 32'd100, 32'd0, lat, bc, dz);
    tests++; if (lat !== 34) begin fails++; $display("FAIL divzero_latency got %0d want 34", lat); end
    tests++; if (dz !== 1'b1) begin fails++; $display("FAIL divzero_flag got %b want 1", dz); end
    tests++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL divzero_hilo_kept got lo=%h hi=%h want lo=fffffffd hi=ffffffff", lo, hi); end
    tick();
    tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL divzero_pulse_width got %b want 0", div_zero); end
  endtask

  task automatic test_overflow();
    int lat, bc; logic dz;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
    tests++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      fails++; $display("FAIL div_overflow got lo=%h hi=%h want lo=80000000 hi=00000000", lo, hi); end
    tests++; if (dz !== 1'b0) begin fails++; $display("FAIL div_overflow_flag got %b want 0", dz); end
  endtask

  task automatic test_hold();
    logic seen;
    seen = 1'b0;
    op = 2'b11; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      start = 1'b0; hilo_read = 1'b0; mt_lo = 1'b0;
      if (done) begin
        hilo_read = 1'b1;
        #1;
        tests++; if (hold !== 1'b0) begin fails++; $display("FAIL hold_done_cycle got %b want 0", hold); end
        tests++; if (lo !== 32'd14 || hi !== 32'd2) begin
          fails++; $display("FAIL hold_result got lo=%h hi=%h want lo=0000000e hi=00000002", lo, hi); end
        hilo_read = 1'b0;
        seen = 1'b1;
        break;
      end
      if (i == 3) begin
        hilo_read = 1'b1; #1;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL hold_read got %b want 1", hold); end
      end else if (i == 4) begin
        start = 1'b1; op = 2'b00; operand_a = 32'd9; operand_b = 32'd9; #1;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL hold_start got %b want 1", hold); end
      end else if (i == 5) begin
        mt_lo = 1'b1; mt_data = 32'hDEAD_BEEF; #1;
        tests++; if (hold !== 1'b1) begin fails++; $display("FAIL hold_mtlo got %b want 1", hold); end
      end else if (i == 6) begin
        #1;
        tests++; if (hold !== 1'b0) begin fails++; $display("FAIL hold_quiet got %b want 0", hold); end
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL hold_timeout got no done want done"); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic dz;
    run_op(2'b01, 32'd6, 32'd7, lat, bc, dz);
    run_op(2'b01, 32'd3, 32'd5, lat, bc, dz);
    tests++; if (lat !== 34) begin fails++; $display("FAIL b2b_latency got %0d want 34", lat); end
    tests++; if (lo !== 32'd15 || hi !== 32'd0) begin
      fails++; $display("FAIL b2b_result got %h_%h want 00000000_0000000f", hi, lo); end
  endtask

  task automatic test_rst_abort();
    int lat, bc, dcount; logic dz;
    op = 2'b01; operand_a = 32'd5; operand_b = 32'd5; start = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL abort_hilo got %h/%h want 0/0", hi, lo); end
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcount++;
    end
    tests++; if (dcount !== 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", dcount); end
    run_op(2'b01, 32'd5, 32'd5, lat, bc, dz);
    tests++; if (lat !== 34 || lo !== 32'd25 || hi !== 32'd0) begin
      fails++; $display("FAIL abort_restart got lat=%0d %h_%h want lat=34 00000000_00000019", lat, hi, lo); end
  endtask

  task automatic test_mt();
    logic seen;
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h1234_5678;
    tick();
    mt_hi = 1'b0; mt_lo = 1'b0;
    tests++; if (hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
      fails++; $display("FAIL mt_both got %h/%h want 12345678/12345678", hi, lo); end
    mt_hi = 1'b1; mt_data = 32'hAAAA_5555;
    tick();
    mt_hi = 1'b0;
    tests++; if (hi !== 32'hAAAA_5555 || lo !== 32'h1234_5678) begin
      fails++; $display("FAIL mt_hi_only got %h/%h want aaaa5555/12345678", hi, lo); end
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hCAFE_F00D;
    op = 2'b01; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    tests++; if (busy !== 1'b1 || hi !== 32'hAAAA_5555 || lo !== 32'h1234_5678) begin
      fails++; $display("FAIL mt_vs_start got busy=%b %h/%h want busy=1 aaaa5555/12345678", busy, hi, lo); end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) begin seen = 1'b1; break; end
    end
    tests++; if (!seen || lo !== 32'd6 || hi !== 32'd0) begin
      fails++; $display("FAIL mt_vs_start_result got done=%b %h_%h want done=1 00000000_00000006", seen, hi, lo); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    hilo_read = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_rst_abort();
    test_mt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
